// File: rtl/i_m_areg_fifo_if.sv
// i_m_areg_fifo_if: inbound flit / memory-access handshake bundle for the areg FIFO
interface i_m_areg_fifo_if #(
  parameter int FLIT_W = 48,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
);
  logic [FLIT_W-1:0] i_flits_m;
  logic v_i_flits_m;
  logic mem_done_access;
  logic [FLIT_W-1:0] i_m_areg_flits;
  logic v_i_areg_m_flits;
  logic i_m_areg_full;
  logic [AW:0] i_m_areg_count;
  logic i_m_areg_ovf;
  modport master (
    output i_flits_m, v_i_flits_m, mem_done_access,
    input i_m_areg_flits, v_i_areg_m_flits, i_m_areg_full, i_m_areg_count, i_m_areg_ovf
  );
  modport slave (
    input i_flits_m, v_i_flits_m, mem_done_access,
    output i_m_areg_flits, v_i_areg_m_flits, i_m_areg_full, i_m_areg_count, i_m_areg_ovf
  );
endinterface

// File: rtl/i_m_areg_fifo.sv
// i_m_areg_fifo: DEPTH-entry flit FIFO feeding local memory; define I_M_AREG_OVF_DETECT_EN for the sticky overflow flag
module i_m_areg_fifo #(
  parameter int FLIT_W = 48,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  i_m_areg_fifo_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push, pop;
  assign push = bus.v_i_flits_m && cnt != FULL_CNT;
  assign pop = bus.mem_done_access && cnt != '0;
  // storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.i_flits_m;
  end
  // pointers and occupancy; acceptance is decided from the registered count only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
    end
  end
  assign bus.i_m_areg_flits = (cnt != '0) ? mem[rp] : '0;
  assign bus.v_i_areg_m_flits = cnt != '0;
  assign bus.i_m_areg_full = cnt == FULL_CNT;
  assign bus.i_m_areg_count = cnt;
`ifdef I_M_AREG_OVF_DETECT_EN
  logic ovf;
  // sticky: any valid flit offered while full latches the flag until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (bus.v_i_flits_m && cnt == FULL_CNT) ovf <= 1'b1;
  end
  assign bus.i_m_areg_ovf = ovf;
`else
  assign bus.i_m_areg_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_i_m_areg_fifo.sv
// tb_i_m_areg_fifo: scoreboard-driven directed test of i_m_areg_fifo
module tb_i_m_areg_fifo;
  logic clk, rst;
  int total = 0;
  int bad = 0;
  logic [47:0] q[$];
  logic eovf = 1'b0;
  i_m_areg_fifo_if #(.FLIT_W(48), .DEPTH(4)) bus ();
  i_m_areg_fifo #(.FLIT_W(48), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    logic [47:0] h;
    h = (q.size() != 0) ? q[0] : 48'h0;
    chk({tag, ".valid"}, 64'(bus.v_i_areg_m_flits), 64'(q.size() != 0));
    chk({tag, ".flits"}, 64'(bus.i_m_areg_flits), 64'(h));
    chk({tag, ".count"}, 64'(bus.i_m_areg_count), 64'(q.size()));
    chk({tag, ".full"}, 64'(bus.i_m_areg_full), 64'(q.size() == 4));
    chk({tag, ".ovf"}, 64'(bus.i_m_areg_ovf), 64'(eovf));
  endtask
  task automatic cyc(input string tag, input logic v, input logic [47:0] d, input logic p);
    int sz;
    bus.v_i_flits_m = v;
    bus.i_flits_m = d;
    bus.mem_done_access = p;
    @(posedge clk);
    sz = q.size();
`ifdef I_M_AREG_OVF_DETECT_EN
    if (v && sz == 4) eovf = 1'b1;
`endif
    if (p && sz != 0) void'(q.pop_front());
    if (v && sz < 4) q.push_back(d);
    #1;
    bus.v_i_flits_m = 1'b0;
    bus.i_flits_m = '0;
    bus.mem_done_access = 1'b0;
    check_all(tag);
  endtask
  initial begin
    rst = 1'b1;
    bus.v_i_flits_m = 1'b0;
    bus.i_flits_m = '0;
    bus.mem_done_access = 1'b0;
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc("single_push", 1, 48'h0000_1234_ABCD, 0);
    cyc("single_pop", 0, 0, 1);
    for (int i = 1; i <= 4; i++) cyc("fill_a", 1, 48'hA0 + 48'(i), 0);
    cyc("pop_a1", 0, 0, 1);
    cyc("pop_a2", 0, 0, 1);
    cyc("push_a5", 1, 48'hA5, 0);
    cyc("push_a6", 1, 48'hA6, 0);
    for (int i = 0; i < 4; i++) cyc("drain_a", 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("fill_b", 1, 48'hB0 + 48'(i), 0);
    cyc("ovf_push", 1, 48'hBBBB, 0);
    cyc("ovf_hold", 0, 0, 0);
    cyc("full_push_pop", 1, 48'hBCBC, 1);
    cyc("pop_to2", 0, 0, 1);
    cyc("push_pop_at2", 1, 48'hC2C2, 1);
    cyc("push_pop_at2b", 1, 48'hC3C3, 1);
    for (int i = 0; i < 2; i++) cyc("drain_b", 0, 0, 1);
    cyc("pop_empty", 0, 0, 1);
    cyc("pop_empty2", 0, 0, 1);
    cyc("after_empty_push", 1, 48'hD1D1, 0);
    cyc("after_empty_pop", 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("pre_rst", 1, 48'hE0 + 48'(i), 0);
    cyc("pre_rst_ovf", 1, 48'hE3, 0);
    cyc("pre_rst_more", 1, 48'hE4, 0);
    cyc("to3", 0, 0, 1);
    #2;
    rst = 1'b1;
    q.delete();
    eovf = 1'b0;
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst_c", 1, 48'hC0FFEE, 0);
    cyc("post_rst_c2", 1, 48'hC0FFEF, 0);
    cyc("post_rst_pop", 0, 0, 1);
    cyc("post_rst_pop2", 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
